ula_ctrl: RTL and testbench

ULA_CTRL -- requirements
Module: ula_ctrl

---
 rtl/ula_ctrl_if.sv | 27 ++
 rtl/ula_ctrl.sv | 104 ++++++++++
 tb/tb_ula_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_ctrl_if.sv
// Handshake, operand-stack and ALU bus between ula_ctrl (master) and its environment (slave).
interface ula_ctrl_if #(parameter int DATA_SIZE = 11);
  logic                 start;
  logic [3:0]           opcode;
  logic                 busy;
  logic                 done;
  logic [1:0]           err_code;
  logic                 stk_empty;
  logic [DATA_SIZE-1:0] stk_top;
  logic                 stk_pop;
  logic                 stk_push;
  logic [DATA_SIZE-1:0] stk_wdata;
  logic [3:0]           ula_opcode;
  logic [DATA_SIZE-1:0] ula_a;
  logic [DATA_SIZE-1:0] ula_b;
  logic [DATA_SIZE-1:0] ula_out;

  modport master (
    input  start, opcode, stk_empty, stk_top, ula_out,
    output busy, done, err_code, stk_pop, stk_push, stk_wdata, ula_opcode, ula_a, ula_b
  );

  modport slave (
    output start, opcode, stk_empty, stk_top, ula_out,
    input  busy, done, err_code, stk_pop, stk_push, stk_wdata, ula_opcode, ula_a, ula_b
  );
endinterface

// File: rtl/ula_ctrl.sv
// Stack-machine sequencer for one ula instruction: pop B, pop A, execute, push result.
// Error paths (illegal opcode, underflow, divide by zero) short-circuit to DONE.
module ula_ctrl #(
  parameter int DATA_SIZE = 11
) (
  input logic        clk,
  input logic        rst_n,
  ula_ctrl_if.master bus
);

  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd12;
  localparam logic [3:0] OP_NOT = 4'd13;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_DIVZERO   = 2'd3;

  typedef enum logic [2:0] {
    IDLE, POP_B, POP_A, EXEC, PUSH, DONE
  } state_t;

  state_t               state;
  logic [3:0]           op_q;
  logic [DATA_SIZE-1:0] a_q;
  logic [DATA_SIZE-1:0] b_q;
  logic [DATA_SIZE-1:0] res_q;
  logic [1:0]           err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.opcode;
            err_q <= ERR_NONE;
            // NOT skips POP_B, so B must read as zero for it
            b_q   <= '0;
            if (bus.opcode >= OP_ADD && bus.opcode <= OP_CMP) begin
              state <= POP_B;
            end else if (bus.opcode == OP_NOT) begin
              state <= POP_A;
            end else begin
              err_q <= ERR_ILLEGAL;
              state <= DONE;
            end
          end
        end
        POP_B: begin
          if (bus.stk_empty) begin
            err_q <= ERR_UNDERFLOW;
            state <= DONE;
          end else begin
            b_q   <= bus.stk_top;
            state <= POP_A;
          end
        end
        POP_A: begin
          if (bus.stk_empty) begin
            err_q <= ERR_UNDERFLOW;
            state <= DONE;
          end else begin
            a_q   <= bus.stk_top;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_DIV && b_q == '0) begin
            err_q <= ERR_DIVZERO;
            state <= DONE;
          end else begin
            res_q <= bus.ula_out;
            state <= PUSH;
          end
        end
        PUSH:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pop must coincide with the cycle that captures stk_top, so it is
  // decoded from state plus the stack's own empty flag, never from start.
  assign bus.stk_pop    = (state == POP_B || state == POP_A) && !bus.stk_empty;
  assign bus.stk_push   = (state == PUSH);
  assign bus.stk_wdata  = res_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.err_code   = err_q;
  assign bus.ula_opcode = op_q;
  assign bus.ula_a      = a_q;
  assign bus.ula_b      = b_q;

endmodule

// File: tb/tb_ula_ctrl.sv
// Self-checking bench for ula_ctrl: stack + ALU environment model, directed and random instructions
// compared against an instruction-level reference (pops, push value, error, latency).
module tb_ula_ctrl;
  localparam int DW   = 11;
  localparam int MASK = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_ctrl_if #(.DATA_SIZE(DW)) bus();

  ula_ctrl #(.DATA_SIZE(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // ALU behaviour of the attached ula; CMP yields 1 / -1 / 0, NOT is logical
  function automatic int alu(input int op, input int a, input int b);
    int r;
    case (op)
      4:       r = a + b;
      5:       r = a - b;
      6:       r = a * b;
      7:       r = (b == 0) ? 0 : a / b;
      8:       r = a & b;
      9:       r = ~(a & b);
      10:      r = a | b;
      11:      r = a ^ b;
      12:      r = (a > b) ? 1 : ((a < b) ? -1 : 0);
      13:      r = (a == 0) ? 1 : 0;
      default: r = 0;
    endcase
    return r & MASK;
  endfunction

  always_comb bus.ula_out = DW'(alu(int'(bus.ula_opcode), int'(bus.ula_a), int'(bus.ula_b)));

  // Operand stack model plus event counters, all updated on the clock edge
  logic [DW-1:0] stk_mem [64];
  int   stk_cnt   = 0;
  int   cyc       = 0;
  int   n_pop     = 0;
  int   n_push    = 0;
  int   n_done    = 0;
  int   n_overlap = 0;
  int   done_cyc  = 0;
  int   last_push = 0;
  int   push_b    = 0;
  logic clr_en    = 1'b0;
  logic load_en   = 1'b0;
  logic [DW-1:0] load_val = '0;

  assign bus.stk_empty = (stk_cnt == 0);
  assign bus.stk_top   = (stk_cnt > 0) ? stk_mem[stk_cnt-1] : '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_en) begin
      stk_cnt <= 0;
    end else if (load_en) begin
      stk_mem[stk_cnt] <= load_val;
      stk_cnt <= stk_cnt + 1;
    end else if (bus.stk_push === 1'b1) begin
      stk_mem[stk_cnt] <= bus.stk_wdata;
      stk_cnt <= stk_cnt + 1;
    end else if (bus.stk_pop === 1'b1 && stk_cnt > 0) begin
      stk_cnt <= stk_cnt - 1;
    end
    if (bus.stk_pop === 1'b1) n_pop <= n_pop + 1;
    if (bus.stk_push === 1'b1) begin
      n_push    <= n_push + 1;
      last_push <= int'(bus.stk_wdata);
      push_b    <= int'(bus.ula_b);
    end
    if (bus.stk_pop === 1'b1 && bus.stk_push === 1'b1) n_overlap <= n_overlap + 1;
    if (bus.done === 1'b1) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  task automatic load_stack(input int n, input int v0, input int v1, input int v2);
    int vals[3];
    vals = '{v0, v1, v2};
    @(posedge clk); #1 clr_en = 1'b1;
    @(posedge clk); #1 clr_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      load_en = 1'b1; load_val = DW'(vals[k]);
      @(posedge clk); #1;
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    int d0;
    rst_n = 1'b0; bus.start = 1'b1; bus.opcode = 4'd3;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; bus.start = 1'b0;
    d0 = n_done;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
    vectors++; if (bus.stk_pop !== 1'b0 || bus.stk_push !== 1'b0) begin
      errors++; $display("FAIL reset strobes: got pop=%b push=%b want 0/0", bus.stk_pop, bus.stk_push); end
    vectors++; if (bus.err_code !== 2'd0) begin errors++; $display("FAIL reset err_code: got %0d want 0", bus.err_code); end
    vectors++; if (bus.ula_opcode !== 4'd0 || bus.ula_a !== '0 || bus.ula_b !== '0 || bus.stk_wdata !== '0) begin
      errors++; $display("FAIL reset regs: got op=%0d a=%0d b=%0d wdata=%0d want all 0",
                         bus.ula_opcode, bus.ula_a, bus.ula_b, bus.stk_wdata); end
    repeat (3) @(negedge clk);
    vectors++; if (n_done != d0) begin errors++; $display("FAIL reset_priority done pulses: got %0d want 0", n_done - d0); end
  endtask

  // One instruction on a freshly loaded stack (v0 bottom .. top), checked against the reference
  task automatic run_instr(input string nm, input int op, input int n,
                           input int v0, input int v1, input int v2);
    int vals[3];
    int exp_err, exp_pops, exp_lat, exp_val, a, b, p0, q0, d0, sc, exp_left;
    bit exp_push;
    vals = '{v0 & MASK, v1 & MASK, v2 & MASK};
    load_stack(n, vals[0], vals[1], vals[2]);
    exp_push = 1'b0; exp_val = 0; exp_err = 0;
    if (op < 4 || op > 13) begin
      exp_err = 1; exp_pops = 0; exp_lat = 1;
    end else if (op == 13) begin
      if (n < 1) begin exp_err = 2; exp_pops = 0; exp_lat = 2; end
      else begin exp_pops = 1; exp_lat = 4; exp_push = 1'b1; exp_val = alu(13, vals[n-1], 0); end
    end else begin
      if (n == 0)      begin exp_err = 2; exp_pops = 0; exp_lat = 2; end
      else if (n == 1) begin exp_err = 2; exp_pops = 1; exp_lat = 3; end
      else begin
        b = vals[n-1]; a = vals[n-2]; exp_pops = 2;
        if (op == 7 && b == 0) begin exp_err = 3; exp_lat = 4; end
        else begin exp_push = 1'b1; exp_lat = 5; exp_val = alu(op, a, b); end
      end
    end
    exp_left = n - exp_pops + (exp_push ? 1 : 0);
    p0 = n_pop; q0 = n_push; d0 = n_done;
    bus.opcode = 4'(op); bus.start = 1'b1; sc = cyc;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 0; k < 20 && n_done == d0; k++) @(negedge clk);
    vectors++; if (n_done == d0) begin errors++; $display("FAIL %s timeout: got no done within 20 cycles, want done", nm); end
    vectors++; if (done_cyc - sc != exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, done_cyc - sc, exp_lat); end
    vectors++; if (bus.err_code !== 2'(exp_err)) begin errors++; $display("FAIL %s err_code: got %0d want %0d", nm, bus.err_code, exp_err); end
    vectors++; if (n_pop - p0 != exp_pops) begin errors++; $display("FAIL %s pops: got %0d want %0d", nm, n_pop - p0, exp_pops); end
    vectors++; if (n_push - q0 != (exp_push ? 1 : 0)) begin errors++; $display("FAIL %s pushes: got %0d want %0d", nm, n_push - q0, exp_push); end
    if (exp_push) begin
      vectors++; if (last_push != exp_val) begin errors++; $display("FAIL %s push data: got %0d want %0d", nm, last_push, exp_val); end
      if (op == 13) begin
        vectors++; if (push_b != 0) begin errors++; $display("FAIL %s ula_b: got %0d want 0", nm, push_b); end
      end
    end
    vectors++; if (stk_cnt != exp_left) begin errors++; $display("FAIL %s stack depth: got %0d want %0d", nm, stk_cnt, exp_left); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy after done: got %b want 0", nm, bus.busy); end
    repeat (2) @(negedge clk);
    vectors++; if (n_done - d0 != 1 || bus.err_code !== 2'(exp_err)) begin
      errors++; $display("FAIL %s hold: got done=%0d err=%0d want 1/%0d", nm, n_done - d0, bus.err_code, exp_err); end
  endtask

  task automatic test_directed();
    run_instr("sub",      5,  2, 20, 10, 0);
    run_instr("mul",      6,  2, 24, 25, 0);
    run_instr("div",      7,  2, 13, 5, 0);
    run_instr("cmp_gt",   12, 2, 123, 122, 0);
    run_instr("cmp_lt",   12, 2, 123, 124, 0);
    run_instr("cmp_eq",   12, 2, 123, 123, 0);
    run_instr("not",      13, 1, 123, 0, 0);
    run_instr("add_under",4,  1, 7, 0, 0);
    run_instr("illegal",  3,  2, 1, 2, 0);
    run_instr("div_zero", 7,  2, 13, 0, 0);
    run_instr("not_empty",13, 0, 0, 0, 0);
    run_instr("xor_deep", 11, 3, 99, 1365, 682);
  endtask

  task automatic test_start_while_busy();
    int p0, q0, d0, sc;
    load_stack(2, 13, 5, 0);
    p0 = n_pop; q0 = n_push; d0 = n_done;
    bus.opcode = 4'd7; bus.start = 1'b1; sc = cyc;
    @(posedge clk); #1 bus.opcode = 4'd3;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b want 1", bus.busy); end
    for (int k = 0; k < 20 && n_done == d0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++; if (n_done - d0 != 1 || done_cyc - sc != 5) begin
      errors++; $display("FAIL busy_ignore done: got %0d pulses at +%0d want 1 at +5", n_done - d0, done_cyc - sc); end
    vectors++; if (n_pop - p0 != 2 || n_push - q0 != 1 || last_push != 2 || bus.err_code !== 2'd0) begin
      errors++; $display("FAIL busy_ignore result: got pops=%0d pushes=%0d data=%0d err=%0d want 2/1/2/0",
                         n_pop - p0, n_push - q0, last_push, bus.err_code); end
  endtask

  task automatic test_reset_mid_exec();
    int p0, q0, d0;
    load_stack(2, 20, 10, 0);
    p0 = n_pop; q0 = n_push; d0 = n_done;
    bus.opcode = 4'd5; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    vectors++; if (n_push - q0 != 0 || n_done - d0 != 0) begin
      errors++; $display("FAIL rst_exec activity: got pushes=%0d dones=%0d want 0/0", n_push - q0, n_done - d0); end
    vectors++; if (n_pop - p0 != 2 || stk_cnt != 0) begin
      errors++; $display("FAIL rst_exec stack: got pops=%0d depth=%0d want 2/0", n_pop - p0, stk_cnt); end
    vectors++; if (bus.busy !== 1'b0 || bus.ula_a !== '0 || bus.ula_b !== '0 || bus.err_code !== 2'd0) begin
      errors++; $display("FAIL rst_exec state: got busy=%b a=%0d b=%0d err=%0d want 0/0/0/0",
                         bus.busy, bus.ula_a, bus.ula_b, bus.err_code); end
  endtask

  task automatic test_random();
    int op, n, v[3];
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(4, 13)) : int'($urandom_range(0, 15));
      n  = int'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) v[k] = int'($urandom_range(0, MASK));
      if (op == 7 && n > 0 && $urandom_range(0, 2) == 0) v[n-1] = 0;
      run_instr($sformatf("rand%0d_op%0d", i, op), op, n, v[0], v[1], v[2]);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.opcode = 4'd0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_exec();
    test_random();
    vectors++; if (n_overlap != 0) begin errors++; $display("FAIL pop_push_overlap: got %0d cycles want 0", n_overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
